// File: rtl/led_pkg.sv
// Shared types and constants for the LED display blocks.
// Also carries the gamma mapping used when LED_BAR_GAMMA_EN is defined.
package led_pkg;

    typedef enum logic [1:0] {IDLE, UP, DOWN} fade_state_t;

    localparam int LED_COUNT = 8;
    localparam int PWM_BITS  = 5;
    localparam int LEVEL_W   = 8;
    localparam int SEG_BITS  = LEVEL_W - PWM_BITS;

    // Squared-law brightness curve: (x*x)>>8 taken from a 16-bit product.
    function automatic logic [LEVEL_W-1:0] gamma_map(input logic [LEVEL_W-1:0] x);
        logic [2*LEVEL_W-1:0] prod;
        prod = (2*LEVEL_W)'(x) * (2*LEVEL_W)'(x);
        return prod[2*LEVEL_W-1:LEVEL_W];
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Fade-rate tick generator: counts 0..PRESCALE-1 and flags the last count.
// With PRESCALE=1 the tick is asserted every cycle.
module led_tick_gen #(
    parameter int PRESCALE = 1000
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            count_reg <= '0;
        end else if (count_reg == LAST) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign tick = (count_reg == LAST);

endmodule

// File: rtl/led_bar_fader.sv
// Fades a displayed level toward an 8-bit brightness target and renders it on an
// 8-LED bar with PWM on the partial LED. Optional gamma curve: LED_BAR_GAMMA_EN.
module led_bar_fader
    import led_pkg::*;
#(
    parameter int PRESCALE = 1000,
    parameter int STEP     = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [LEVEL_W-1:0] data_in,
    output logic [LEVEL_W-1:0] led_out,
    output logic [LEVEL_W-1:0] level_out,
    output logic               busy
);

    localparam logic [LEVEL_W:0] STEP_9 = (LEVEL_W+1)'(STEP);

    logic                  tick;
    logic [LEVEL_W-1:0]    target_reg;
    logic [LEVEL_W-1:0]    target_next;
    logic [LEVEL_W-1:0]    level_reg;
    fade_state_t           state_reg;
    logic                  busy_reg;
    logic [PWM_BITS-1:0]   pwm_reg;
    logic [LED_COUNT-1:0]  led_reg;
    logic [LED_COUNT-1:0]  led_next;

    led_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

`ifdef LED_BAR_GAMMA_EN
    assign target_next = gamma_map(data_in);
`else
    assign target_next = data_in;
`endif

    // One extra bit of headroom so the step can never wrap past 255 or below 0.
    logic [LEVEL_W:0]        up_sum;
    logic signed [LEVEL_W:0] dn_diff;
    logic [LEVEL_W-1:0]      up_level;
    logic [LEVEL_W-1:0]      dn_level;

    assign up_sum   = {1'b0, level_reg} + STEP_9;
    assign dn_diff  = $signed({1'b0, level_reg}) - $signed(STEP_9);
    assign up_level = (up_sum > {1'b0, target_reg}) ? target_reg : up_sum[LEVEL_W-1:0];
    assign dn_level = (dn_diff < $signed({1'b0, target_reg})) ? target_reg
                                                              : dn_diff[LEVEL_W-1:0];

    logic [SEG_BITS-1:0] seg;
    logic [PWM_BITS-1:0] duty;

    assign seg  = level_reg[LEVEL_W-1:PWM_BITS];
    assign duty = level_reg[PWM_BITS-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < LED_COUNT; gi++) begin : g_bar
            localparam logic [SEG_BITS-1:0] IDX = SEG_BITS'(gi);
            assign led_next[gi] = (IDX < seg) || ((IDX == seg) && (pwm_reg < duty));
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            target_reg <= '0;
            level_reg  <= '0;
            state_reg  <= IDLE;
            busy_reg   <= 1'b0;
            pwm_reg    <= '0;
            led_reg    <= '0;
        end else begin
            target_reg <= target_next;
            pwm_reg    <= pwm_reg + 1'b1;
            led_reg    <= led_next;
            case (state_reg)
                IDLE: begin
                    if (target_reg > level_reg) begin
                        state_reg <= UP;
                        busy_reg  <= 1'b1;
                    end else if (target_reg < level_reg) begin
                        state_reg <= DOWN;
                        busy_reg  <= 1'b1;
                    end
                end
                UP: begin
                    if (target_reg == level_reg) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else if (target_reg < level_reg) begin
                        state_reg <= DOWN;
                    end else if (tick) begin
                        level_reg <= up_level;
                    end
                end
                DOWN: begin
                    if (target_reg == level_reg) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else if (target_reg > level_reg) begin
                        state_reg <= UP;
                    end else if (tick) begin
                        level_reg <= dn_level;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign led_out   = led_reg;
    assign level_out = level_reg;
    assign busy      = busy_reg;

endmodule
